// File: rtl/single_to_int_pkg.sv
// Shared constants for the single-precision float blocks: FSM encoding and
// the IEEE-754 single exponent limits used when converting to integers.
package single_to_int_pkg;

    localparam logic [2:0] ST_GET_A    = 3'd0;
    localparam logic [2:0] ST_UNPACK   = 3'd1;
    localparam logic [2:0] ST_SPECIAL  = 3'd2;
    localparam logic [2:0] ST_CONVERT  = 3'd3;
    localparam logic [2:0] ST_PUT_Z    = 3'd4;

    localparam logic signed [9:0] EXP_BIAS      = 10'sd127;
    localparam logic signed [9:0] EXP_DENORM    = -10'sd127;
    localparam logic signed [9:0] MAX_INT_EXP   = 10'sd30;
    localparam logic signed [9:0] CONV_DONE_EXP = 10'sd31;
    localparam logic [31:0]       INT_MIN       = 32'h8000_0000;

    function automatic logic signed [9:0] unbias_exp(input logic [7:0] biased);
        return $signed({2'b00, biased}) - EXP_BIAS;
    endfunction

endpackage

// File: rtl/single_to_int.sv
// IEEE-754 single to signed 32-bit integer, truncating toward zero, with a
// strobe/ack handshake on both sides; one FSM step per clock.
module single_to_int
    import single_to_int_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] input_a,
    input  logic        input_a_stb,
    output logic        input_a_ack,
    output logic [31:0] output_z,
    output logic        output_z_stb,
    input  logic        output_z_ack
);

    logic [2:0]        state;
    logic [31:0]       a;
    logic [31:0]       a_m;
    logic signed [9:0] a_e;
    logic              a_s;
    logic [31:0]       z;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_GET_A;
            input_a_ack  <= 1'b0;
            output_z_stb <= 1'b0;
            output_z     <= 32'h0;
        end else begin
            case (state)
                ST_GET_A: begin
                    input_a_ack <= 1'b1;
                    if (input_a_ack && input_a_stb) begin
                        a           <= input_a;
                        input_a_ack <= 1'b0;
                        state       <= ST_UNPACK;
                    end
                end

                ST_UNPACK: begin
                    a_m   <= {1'b1, a[22:0], 8'b0};
                    a_e   <= unbias_exp(a[30:23]);
                    a_s   <= a[31];
                    state <= ST_SPECIAL;
                end

                // Out-of-range operands are loaded as a finished mantissa so
                // every result leaves through the single terminal convert step.
                ST_SPECIAL: begin
                    state <= ST_CONVERT;
                    if (a_e == EXP_DENORM || a_e < 10'sd0) begin
                        a_m <= 32'h0;
                        a_s <= 1'b0;
                        a_e <= CONV_DONE_EXP;
                    end else if (a_e > MAX_INT_EXP) begin
                        a_m <= INT_MIN;
                        a_s <= 1'b0;
                        a_e <= CONV_DONE_EXP;
                    end
                end

                ST_CONVERT: begin
                    if (a_e < CONV_DONE_EXP) begin
                        a_m <= a_m >> 1;
                        a_e <= a_e + 10'sd1;
                    end else begin
                        z     <= a_s ? -a_m : a_m;
                        state <= ST_PUT_Z;
                    end
                end

                ST_PUT_Z: begin
                    output_z_stb <= 1'b1;
                    output_z     <= z;
                    if (output_z_stb && output_z_ack) begin
                        output_z_stb <= 1'b0;
                        state        <= ST_GET_A;
                    end
                end

                default: state <= ST_GET_A;
            endcase
        end
    end

endmodule

// File: tb/tb_single_to_int.sv
// Randomised scoreboard bench for single_to_int against an arithmetic
// float-to-int model, including backpressure and mid-conversion reset.
module tb_single_to_int;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] input_a;
    logic        input_a_stb;
    logic        input_a_ack;
    logic [31:0] output_z;
    logic        output_z_stb;
    logic        output_z_ack = 1'b0;

    always #5 clk = ~clk;

    single_to_int dut (
        .clk          (clk),
        .rst          (rst),
        .input_a      (input_a),
        .input_a_stb  (input_a_stb),
        .input_a_ack  (input_a_ack),
        .output_z     (output_z),
        .output_z_stb (output_z_stb),
        .output_z_ack (output_z_ack)
    );

    typedef struct {
        logic [31:0] z;
        int          lat;
        int          dly;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passes = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    bit   in_xfer = 1'b0;
    int   ack_wait = 0;
    int   post = 0;
    logic [31:0] held = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %h, expected %h", name, act, req);
    endtask

    // Reference: value = 1.frac * 2^e, truncated toward zero.
    function automatic exp_t model(input logic [31:0] f, input int dly);
        exp_t   r;
        int     e;
        longint m;
        longint mag;
        e = int'(f[30:23]) - 127;
        m = longint'({1'b1, f[22:0]});
        r.dly = dly;
        if (e < 0) begin
            r.z   = 32'h0;
            r.lat = 4;
        end else if (e > 30) begin
            r.z   = 32'h8000_0000;
            r.lat = 4;
        end else begin
            mag   = (e >= 23) ? (m << (e - 23)) : (m >> (23 - e));
            r.z   = f[31] ? 32'(-mag) : 32'(mag);
            r.lat = 35 - e;
        end
        return r;
    endfunction

    always @(posedge clk) cyc++;

    // Monitor: owns output_z_ack, pops the scoreboard on each new result.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            in_xfer      = 1'b0;
            post         = 0;
            output_z_ack = 1'b0;
        end else begin
            if (output_z_stb) chk("ack_stb_exclusive", {31'h0, input_a_ack}, 32'h0);
            if (post == 1) begin
                chk("stb_drop_after_ack", {31'h0, output_z_stb}, 32'h0);
                post = 2;
            end else if (post == 2) begin
                chk("ack_rise_after_put", {31'h0, input_a_ack}, 32'h1);
                post = 0;
            end
            if (output_z_stb && !in_xfer) begin
                if (sb.size() == 0) begin
                    chk("unexpected_output", 32'h1, 32'h0);
                end else begin
                    e = sb.pop_front();
                    chk("output_z", output_z, e.z);
                    chk("latency", 32'(cyc - acc_cyc), 32'(e.lat));
                    held     = output_z;
                    ack_wait = e.dly;
                    in_xfer  = 1'b1;
                end
            end else if (output_z_stb && in_xfer) begin
                chk("output_z_stable", output_z, held);
            end
            if (in_xfer) begin
                if (ack_wait == 0) begin
                    output_z_ack = 1'b1;
                    in_xfer      = 1'b0;
                    post         = 1;
                end else begin
                    ack_wait--;
                    output_z_ack = 1'b0;
                end
            end else if (!output_z_stb) begin
                output_z_ack = 1'($urandom_range(0, 1));
            end else begin
                output_z_ack = 1'b0;
            end
        end
    end

    task automatic send(input logic [31:0] v, input int dly, input bit track);
        int waited;
        repeat ($urandom_range(0, 3)) @(negedge clk);
        input_a     = v;
        input_a_stb = 1'b1;
        waited      = 0;
        while (!input_a_ack && waited <= 300) begin
            @(negedge clk);
            waited++;
        end
        if (!input_a_ack) begin
            chk("accept_timeout", 32'h0, 32'h1);
        end else begin
            acc_cyc = cyc + 1;
            if (track) sb.push_back(model(v, dly));
        end
        @(negedge clk);
        input_a_stb = 1'b0;
        input_a     = $urandom;
    endtask

    logic [31:0] dir_v[11] = '{32'h3F80_0000, 32'hC020_0000, 32'h47F1_2000, 32'h3F40_0000,
                               32'h8000_0000, 32'h0000_0001, 32'h4F00_0000, 32'h7F80_0000,
                               32'h7FC0_0000, 32'hCF00_0000, 32'h47F1_2000};
    int          dir_d[11] = '{0, 1, 0, 2, 0, 0, 1, 0, 3, 0, 5};

    initial begin
        int          waited;
        logic [31:0] f;
        rst         = 1'b1;
        input_a     = 32'h0;
        input_a_stb = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_stb", {31'h0, output_z_stb}, 32'h0);
        chk("reset_ack", {31'h0, input_a_ack}, 32'h0);
        chk("reset_z", output_z, 32'h0);
        rst = 1'b0;

        foreach (dir_v[i]) send(dir_v[i], dir_d[i], 1'b1);

        // Reset during conversion of 1.0 discards it.
        waited = 0;
        while ((sb.size() != 0 || in_xfer || post != 0) && waited < 500) begin
            @(negedge clk);
            waited++;
        end
        send(32'h3F80_0000, 0, 1'b0);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_stb", {31'h0, output_z_stb}, 32'h0);
        chk("midrst_z", output_z, 32'h0);
        chk("midrst_ack_low", {31'h0, input_a_ack}, 32'h0);
        @(negedge clk);
        chk("midrst_ack_rise", {31'h0, input_a_ack}, 32'h1);
        send(32'h4040_0000, 0, 1'b1);

        for (int n = 0; n < 150; n++) begin
            f[31]    = 1'($urandom_range(0, 1));
            f[30:23] = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(120, 162));
            f[22:0]  = 23'($urandom);
            send(f, $urandom_range(0, 3), 1'b1);
        end

        waited = 0;
        while ((sb.size() != 0 || in_xfer || post != 0) && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        if (sb.size() != 0 || in_xfer) chk("drain_timeout", 32'(sb.size()), 32'h0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
